// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron MAC sequencer.
//   state_t      : sequencer FSM states
//   acc_width()  : accumulator width that can never wrap for N products
//   saturate()   : clamp an unsigned value to the largest data_w-bit value
//   DEFAULT_*    : default RAM layout (inputs, weights, result address)
package neuron_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_X,
        S_LOAD_W,
        S_WRITE,
        S_DONE
    } state_t;

    localparam int DEFAULT_INPUT_BASE  = 0;
    localparam int DEFAULT_WEIGHT_BASE = 4;
    localparam int DEFAULT_OUTPUT_ADDR = 20;

    // Each product is 2*data_w bits; summing n_inputs of them needs
    // clog2(n_inputs) extra bits of headroom.
    function automatic int acc_width(input int data_w, input int n_inputs);
        return 2 * data_w + $clog2(n_inputs);
    endfunction

    // Operates on a 64-bit carrier so it can serve any accumulator up to
    // 64 bits; callers truncate the result back to data_w.
    function automatic logic [63:0] saturate(input logic [63:0] value,
                                             input int          data_w);
        logic [63:0] max_val;
        max_val = (data_w >= 64) ? '1 : ((64'd1 << data_w) - 64'd1);
        return (value > max_val) ? max_val : value;
    endfunction

endpackage

// File: rtl/neuron_mac_acc.sv
// Unsigned multiply-accumulate with saturated view of the running sum.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : zero the accumulator (takes priority over en)
//   en       : add a*b into the accumulator
//   a, b     : unsigned operands
//   acc      : full-width running sum
//   sat      : acc clamped to DATA_W bits
//   ovf      : acc exceeds the largest DATA_W-bit value
module neuron_mac_acc
    import neuron_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc,
    output logic [DATA_W-1:0] sat,
    output logic              ovf
);

    logic [2*DATA_W-1:0] product;

    // Zero-extend both operands so the product is computed at full width.
    assign product = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

    // NOTE: registered state is always updated with non-blocking (<=)
    // assignments so every flop samples values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(product);
        end
    end

    assign sat = DATA_W'(saturate(64'(acc), DATA_W));
    // Any set bit above the data width means acc > 2^DATA_W-1.
    assign ovf = |acc[ACC_W-1:DATA_W];

endmodule

// File: rtl/neuron_mac_sequencer.sv
// Neuron evaluation sequencer: bus master of the neuron's dual-port RAM.
// On start, reads N_INPUTS activation/weight pairs, multiply-accumulates
// them, and writes the saturated sum to OUTPUT_ADDR.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : request one evaluation (sampled only in IDLE)
//   busy, done    : run in progress / one-cycle completion pulse
//   result        : last written saturated value
//   overflow      : last run saturated
//   read_address, oe, read_data           : RAM read port
//   write_address, write_data, wre        : RAM write port
module neuron_mac_sequencer
    import neuron_pkg::*;
#(
    parameter int N_INPUTS    = 4,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int INPUT_BASE  = DEFAULT_INPUT_BASE,
    parameter int WEIGHT_BASE = DEFAULT_WEIGHT_BASE,
    parameter int OUTPUT_ADDR = DEFAULT_OUTPUT_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              overflow,
    output logic [ADDR_W-1:0] read_address,
    output logic              oe,
    input  logic [DATA_W-1:0] read_data,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_data,
    output logic              wre
);

    localparam int ACC_W = acc_width(DATA_W, N_INPUTS);
    localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

    state_t              state;
    state_t              state_next;
    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   x_reg;
    logic [ACC_W-1:0]    acc;
    logic [DATA_W-1:0]   acc_sat;
    logic                acc_ovf;
    logic                acc_clear;
    logic                acc_en;
    logic                last_pair;

    assign last_pair = (idx == IDX_W'(N_INPUTS - 1));

    neuron_mac_acc #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_acc (
        .clk   (clk),
        .rst   (rst),
        .clear (acc_clear),
        .en    (acc_en),
        .a     (x_reg),
        .b     (read_data),
        .acc   (acc),
        .sat   (acc_sat),
        .ovf   (acc_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // All RAM-facing outputs decode the registered state only; read_data
    // feeds the accumulator, never an output. Because reset clears state
    // asynchronously, wre drops the moment rst rises.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the
        // case statement leaves one unassigned (which would infer a latch).
        state_next    = state;
        busy          = 1'b0;
        done          = 1'b0;
        oe            = 1'b0;
        wre           = 1'b0;
        read_address  = '0;
        write_address = '0;
        write_data    = '0;
        acc_clear     = 1'b0;
        acc_en        = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    acc_clear  = 1'b1;
                    state_next = S_LOAD_X;
                end
            end
            S_LOAD_X: begin
                busy         = 1'b1;
                oe           = 1'b1;
                read_address = ADDR_W'(INPUT_BASE) + ADDR_W'(idx);
                state_next   = S_LOAD_W;
            end
            S_LOAD_W: begin
                busy         = 1'b1;
                oe           = 1'b1;
                read_address = ADDR_W'(WEIGHT_BASE) + ADDR_W'(idx);
                acc_en       = 1'b1;
                state_next   = last_pair ? S_WRITE : S_LOAD_X;
            end
            S_WRITE: begin
                busy          = 1'b1;
                wre           = 1'b1;
                write_address = ADDR_W'(OUTPUT_ADDR);
                write_data    = acc_sat;
                state_next    = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            x_reg    <= '0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx <= '0;
                    end
                end
                S_LOAD_X: begin
                    x_reg <= read_data;
                end
                S_LOAD_W: begin
                    if (!last_pair) begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                S_WRITE: begin
                    result   <= acc_sat;
                    overflow <= acc_ovf;
                end
                default: ;
            endcase
        end
    end

endmodule
